// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with exact and threshold flags, occupancy count,
// sticky error flags, and build-time selection of registered or FWFT read.
module sync_fifo_flags #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 1024,
    parameter int AW       = $clog2(DEPTH),
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] data_in,
    input  logic             rd,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow,
    input  logic             clr_err
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_COUNT   = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_COUNT   = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             rd_acc;
    logic             wr_acc;

    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    assign rd_acc = rd && !empty;
    assign wr_acc = wr && (!full || rd_acc);

    always_comb begin
        count_next = count;
        if (wr_acc && !rd_acc)
            count_next = count + (AW+1)'(1);
        else if (rd_acc && !wr_acc)
            count_next = count - (AW+1)'(1);
    end

    // NOTE: storage has no reset; emptiness is tracked by pointers and count alone.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= data_in;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc)
                rd_ptr <= rd_ptr + AW'(1);
            count        <= count_next;
            full         <= (count_next == FULL_COUNT);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_COUNT);
            almost_empty <= (count_next <= AE_COUNT);
            // A new error in the same cycle as clr_err keeps the flag set.
            overflow     <= (overflow && !clr_err) || (wr && !wr_acc);
            underflow    <= (underflow && !clr_err) || (rd && empty);
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is shown directly; forced to zero while empty so reset reads as 0.
            assign data_out = empty ? '0 : mem[rd_ptr];
            assign valid    = !empty;
        end else begin : g_std
            always_ff @(posedge clk) begin
                if (!reset) begin
                    data_out <= '0;
                    valid    <= 1'b0;
                end else begin
                    valid <= rd_acc;
                    if (rd_acc)
                        data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised synchronous FIFO and the next-generation buffer for the datapath. It stores WIDTH-bit words in a DEPTH-entry memory on a single clock. It provides exact full/empty, programmable almost-full/almost-empty thresholds, an occupancy count, and sticky overflow/underflow error flags. A build-time mode selects either standard registered read or first-word-fall-through (FWFT) presentation.

## Interface
- WIDTH, 128, data word width in bits
- DEPTH, 1024, number of entries; power of two, minimum 4
- AW, $clog2(DEPTH), pointer width (derived; not overridden)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  reset, synchronous, active-low
- wr  input  1  write request
- data_in  input  WIDTH  write data
- rd  input  1  read request (FWFT: acknowledge/pop of the presented word)
- data_out  output  WIDTH  read data
- valid  output  1  data_out holds a valid popped word (standard) / head word (FWFT)
- count  output  AW+1  current occupancy, 0..DEPTH
- full, empty  output  1 each  count == DEPTH / count == 0
- almost_full, almost_empty  output  1 each  threshold flags
- overflow, underflow  output  1 each  sticky error flags
- clr_err  input  1  clears overflow/underflow

## Operation
- rd_acc = rd && !empty; wr_acc = wr && (!full || rd_acc). A write to a full FIFO succeeds only when paired with an accepted read.
- On wr_acc: mem[wr_ptr] <= data_in; wr_ptr increments. On rd_acc: rd_ptr increments. Both pointers are AW bits and wrap modulo DEPTH.
- count <= count + wr_acc - rd_acc. The width is AW+1, so DEPTH is representable.
- full, empty, almost_full and almost_empty are registered and computed from the next count, so they reflect count after the same edge.
- Standard mode (FWFT=0): on rd_acc, data_out <= mem[rd_ptr] and valid <= 1. Otherwise valid <= 0 and data_out holds its last value.
- FWFT mode (FWFT=1): data_out = mem[rd_ptr] and valid = !empty, both combinational from registered state. rd_acc pops the presented word.
- overflow sets on wr && !wr_acc. underflow sets on rd && empty. clr_err clears both flags, but a set in the same cycle wins over the clear.
- Simultaneous wr and rd:
  - When full: both are accepted, count stays DEPTH, FIFO order is preserved.
  - When empty: the write is accepted, the read is rejected and sets underflow, count becomes 1.
- Rejected writes never modify memory or pointers.

## Timing
- Reset (reset==0 at an edge) drives:
  - pointers = 0, count = 0
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0
  - data_out = 0, valid = 0
  - overflow = 0, underflow = 0
- Reset takes priority over wr/rd and discards all stored words, including when applied mid-operation. Memory contents are not cleared.
- Standard read latency is 1 cycle: rd_acc at edge N gives data_out/valid after edge N, for one cycle.
- FWFT write-to-visible latency is 1 cycle: a write at edge N into an empty FIFO drops empty and presents data_out/valid=1 after edge N, with no rd needed.
- Flag update latency is 0 cycles after the causing edge. There is no lag between count and the flags.
- There is no combinational path from wr/rd to any output.

## Test plan
- Reset: reset=0 for 2 cycles with wr=1, data_in=0xFF → count=0, empty=1, almost_empty=1, full=0, valid=0, data_out=0, no word stored.
- Fill (DEPTH=8, AF_LEVEL=6, FWFT=0): write 0x1..0x8 on 8 consecutive cycles.
  - almost_full rises after the 6th edge; almost_empty falls after the 5th edge.
  - full=1 and count=8 after the 8th edge.
  - A 9th write of 0x9 → overflow=1, count stays 8, 0x9 is never read back.
- Drain: rd=1 for 9 cycles from full.
  - data_out = 0x1..0x8, each with valid=1 one cycle after its rd.
  - The 9th rd → underflow=1, valid=0, data_out holds 0x8, empty=1.
  - clr_err=1 then clears both error flags.
- Simultaneous ops:
  - At full with wr+rd (data_in=0xA) → count stays 8, data_out=0x1, and 0xA is read 8th.
  - At empty with wr+rd → count=1, underflow=1, valid=0.
- Wrap-around (DEPTH=8): random wr/rd for 500 cycles, ≥40 words → read stream equals write stream exactly, and count matches a scoreboard every cycle.
- FWFT=1: write 0xA5 at edge N → valid=1, data_out=0xA5 after N with no rd.
  - Write 0x5A, then rd → data_out=0x5A.
  - rd again → valid=0, empty=1.
  - Reset mid-stream with 3 words stored → valid=0 and count=0 the next cycle.
